// File: rtl/div_issue.sv
// div_issue: execute-stage requester for the iterative 32-bit divider.
// Define DIV_RESULT_CACHE_EN to reuse the last result when the operands and signedness repeat.
module div_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i,
  input  logic [2:0]  div_op_i,
  input  logic [4:0]  div_waddr_i,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic [4:0]  div_waddr_o,
  output logic        hold_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_data;

  logic        w_accept;
  logic        w_ready_ok;
  logic        w_echo_ok;
  logic        w_hit;
  logic [31:0] w_hit_data;
  logic        w_unused_busy;

  // funct3[1] selects the remainder (REM/REMU) over the quotient (DIV/DIVU).
  function automatic logic [31:0] sel_word(input logic [2:0] op,
                                           input logic [31:0] quot,
                                           input logic [31:0] rem);
    return op[1] ? rem : quot;
  endfunction

  assign w_unused_busy = div_busy_i;
  assign w_accept      = (r_state == IDLE) && req_i && !flush_i;
  assign w_ready_ok    = (r_state == WAIT) && div_ready_i && !flush_i;
  assign w_echo_ok     = (div_op_i == r_op) && (div_waddr_i == r_rd);

`ifdef DIV_RESULT_CACHE_EN
  logic [31:0] r_c_dividend;
  logic [31:0] r_c_divisor;
  logic [31:0] r_c_quot;
  logic [31:0] r_c_rem;
  logic        r_c_signed;
  logic        r_c_valid;

  assign w_hit = r_c_valid && (rs1_i == r_c_dividend) && (rs2_i == r_c_divisor) &&
                 (r_c_signed == ~op_i[0]);
  assign w_hit_data = sel_word(op_i, r_c_quot, r_c_rem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_dividend <= '0;
      r_c_divisor  <= '0;
      r_c_quot     <= '0;
      r_c_rem      <= '0;
      r_c_signed   <= 1'b0;
      r_c_valid    <= 1'b0;
    end else if (w_ready_ok && w_echo_ok) begin
      r_c_dividend <= r_dividend;
      r_c_divisor  <= r_divisor;
      r_c_quot     <= div_result_i[31:0];
      r_c_rem      <= div_result_i[63:32];
      r_c_signed   <= ~r_op[0];
      r_c_valid    <= 1'b1;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dividend <= rs1_i;
            r_divisor  <= rs2_i;
            r_op       <= op_i;
            r_rd       <= rd_i;
            if (w_hit) begin
              r_data  <= w_hit_data;
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A flush wins over a same-cycle ready; an echo mismatch drops the result.
          if (flush_i) begin
            r_state <= IDLE;
          end else if (div_ready_i) begin
            if (w_echo_ok) begin
              r_data  <= sel_word(r_op, div_result_i[31:0], div_result_i[63:32]);
              r_state <= DONE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Start falls in the ready cycle so the divider never sees a fresh launch.
  assign div_start_o    = (r_state == WAIT) && !div_ready_i && !flush_i;
  assign div_dividend_o = r_dividend;
  assign div_divisor_o  = r_divisor;
  assign div_op_o       = r_op;
  assign div_waddr_o    = r_rd;
  assign hold_o         = w_accept || (r_state == WAIT);
  assign reg_we_o       = (r_state == DONE);
  assign reg_waddr_o    = reg_we_o ? r_rd : '0;
  assign reg_wdata_o    = reg_we_o ? r_data : '0;

`ifndef SYNTHESIS
  a_echo_match: assert property (@(posedge clk) disable iff (!rst) w_ready_ok |-> w_echo_ok);
`endif

endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: directed checks of div_issue against a behavioural iterative divider.
module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_busy_i;
  logic [2:0]  div_op_i;
  logic [4:0]  div_waddr_i;
  logic        div_start_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_waddr_o;
  logic        hold_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  div_issue dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .flush_i(flush_i), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_busy_i(div_busy_i), .div_op_i(div_op_i), .div_waddr_i(div_waddr_i),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_op_o(div_op_o), .div_waddr_o(div_waddr_o), .hold_o(hold_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk = ~clk;

  // Divider stand-in: 32 iterations, divide-by-zero answers at once, abort when start drops.
  logic       m_run, m_done;
  logic [5:0] m_cnt;
  logic [63:0] m_res;

  function automatic logic [63:0] div_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  assign div_busy_i = m_run && !m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 1'b0; m_done <= 1'b0; m_cnt <= '0; m_res <= '0;
      div_ready_i <= 1'b0; div_result_i <= '0; div_op_i <= '0; div_waddr_i <= '0;
    end else begin
      div_ready_i <= 1'b0;
      if (!div_start_o) begin
        m_run <= 1'b0;
        m_done <= 1'b0;
      end else if (!m_run) begin
        m_run <= 1'b1;
        div_op_i <= div_op_o;
        div_waddr_i <= div_waddr_o;
        m_res <= div_calc(div_op_o, div_dividend_o, div_divisor_o);
        if (div_divisor_o == 32'd0) begin
          div_result_i <= div_calc(div_op_o, div_dividend_o, div_divisor_o);
          div_ready_i <= 1'b1;
          m_done <= 1'b1;
        end
        m_cnt <= 6'd31;
      end else if (!m_done) begin
        if (m_cnt == 6'd0) begin
          div_result_i <= m_res;
          div_ready_i <= 1'b1;
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 6'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One request; reports latency (cycles from request to write), start-high cycles, pulses.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output int starts, output int wes,
                       output logic [31:0] wd, output logic [4:0] wa, output logic hold_acc,
                       output logic hold_done, output logic [31:0] dvd);
    lat = -1; starts = 0; wes = 0; wd = '0; wa = '0; hold_done = 1'b1; dvd = '0;
    @(negedge clk);
    req_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    #1 hold_acc = hold_o;
    if (div_start_o) starts++;
    @(negedge clk);
    req_i = 1'b0; rs1_i = '0; rs2_i = '0; rd_i = '0; op_i = '0;
    for (int c = 1; c < 80; c++) begin
      if (c == 1) dvd = div_dividend_o;
      if (div_start_o) starts++;
      if (reg_we_o) begin
        wes++;
        if (lat < 0) begin
          lat = c; wd = reg_wdata_o; wa = reg_waddr_o; hold_done = hold_o;
        end
      end
      if (lat >= 0 && c > lat + 2) break;
      @(negedge clk);
    end
  endtask

  int lat, starts, wes, cnt;
  logic [31:0] wd, dvd;
  logic [4:0] wa;
  logic hacc, hdone;

  initial begin
    #12;
    check("rst_start", 32'(div_start_o), 32'd0);
    check("rst_hold", 32'(hold_o), 32'd0);
    check("rst_we", 32'(reg_we_o), 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);
    check("rst_dividend", div_dividend_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(OP_DIVU, 32'd100, 32'd7, 5'd5, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("divu_wdata", wd, 32'd14);
    check("divu_waddr", 32'(wa), 32'd5);
    check("divu_pulse", 32'(wes), 32'd1);
    check("divu_lat", 32'(lat), 32'd35);
    check("divu_starts", 32'(starts), 32'd33);
    check("divu_hold_acc", 32'(hacc), 32'd1);
    check("divu_hold_done", 32'(hdone), 32'd0);
    check("divu_dividend_out", dvd, 32'd100);

    do_op(OP_REM, 32'hFFFF_FFEC, 32'd3, 5'd9, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("rem_neg", wd, 32'hFFFF_FFFE);
    check("rem_neg_waddr", 32'(wa), 32'd9);
    do_op(OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd10, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("div_neg", wd, 32'hFFFF_FFFA);

    do_op(OP_DIVU, 32'd5, 32'd0, 5'd1, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("divu_by0", wd, 32'hFFFF_FFFF);
    check("divu_by0_lat", 32'(lat), 32'd3);
    do_op(OP_REMU, 32'd5, 32'd0, 5'd2, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("remu_by0", wd, 32'd5);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("div_ovf", wd, 32'h8000_0000);
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("rem_ovf", wd, 32'd0);
    check("rem_ovf_pulse", 32'(wes), 32'd1);

    // Flush ten cycles into WAIT.
    @(negedge clk);
    req_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd6;
    @(negedge clk);
    req_i = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_pre_start", 32'(div_start_o), 32'd1);
    flush_i = 1'b1;
    #1 check("flush_start_low", 32'(div_start_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_idle_hold", 32'(hold_o), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (reg_we_o || div_start_o) cnt++;
    end
    check("flush_no_write", 32'(cnt), 32'd0);
    do_op(OP_DIVU, 32'd9, 32'd3, 5'd11, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("after_flush", wd, 32'd3);
    check("after_flush_waddr", 32'(wa), 32'd11);

    // Flush arriving in the same cycle as ready.
    @(negedge clk);
    req_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd50; rs2_i = 32'd5; rd_i = 5'd12;
    @(negedge clk);
    req_i = 1'b0;
    cnt = 0;
    while (!div_ready_i && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_seen", 32'(div_ready_i), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    cnt = 0;
    repeat (5) begin
      if (reg_we_o) cnt++;
      @(negedge clk);
    end
    check("flush_ready_no_write", 32'(cnt), 32'd0);
    check("flush_ready_hold", 32'(hold_o), 32'd0);

    // Request during flush in IDLE is ignored.
    req_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd8; rs2_i = 32'd2;
    #1 check("idle_flush_hold", 32'(hold_o), 32'd0);
    @(negedge clk);
    req_i = 1'b0; flush_i = 1'b0;
    #1 check("idle_flush_nostart", 32'(div_start_o), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    req_i = 1'b1; op_i = OP_DIV; rs1_i = 32'd77; rs2_i = 32'd7; rd_i = 5'd13;
    @(negedge clk);
    req_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_start", 32'(div_start_o), 32'd0);
    check("arst_hold", 32'(hold_o), 32'd0);
    check("arst_dividend", div_dividend_o, 32'd0);
    check("arst_op", 32'(div_op_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef DIV_RESULT_CACHE_EN
    do_op(OP_DIV, 32'd1000, 32'd10, 5'd7, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("cache_fill", wd, 32'd100);
    do_op(OP_REM, 32'd1000, 32'd10, 5'd8, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("cache_hit_rem", wd, 32'd0);
    check("cache_hit_nostart", 32'(starts), 32'd0);
    check("cache_hit_lat", 32'(lat), 32'd1);
    check("cache_hit_waddr", 32'(wa), 32'd8);
`else
    do_op(OP_DIV, 32'd1000, 32'd10, 5'd7, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("post_rst_div", wd, 32'd100);
    do_op(OP_REM, 32'd1000, 32'd10, 5'd8, lat, starts, wes, wd, wa, hacc, hdone, dvd);
    check("post_rst_rem", wd, 32'd0);
    check("post_rst_rem_waddr", 32'(wa), 32'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
